// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter with pad output-enable control:
// FSM state encoding, frame constants and the minimum usable baud divisor.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_GUARD = 3'd4
   } tx_state_e;

   localparam int   DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   MIN_DIV   = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO with first-word fall-through read data.
// A write on a full FIFO is still taken when a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic             drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push;
   logic             pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign pop     = rd_en && !empty;
   assign push    = wr_en && (!full || pop);
   assign drop    = wr_en && !push;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx_oe.sv
// 8N1 UART transmitter driving a tri-state pad (tx_d data, tx_e enable), with a
// byte FIFO, per-frame latched baud divisor and an optional guard time after stop.
module uart_tx_oe
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int GUARD_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic [7:0]           wr_data,
   input  logic                 wr_en,
   input  logic                 drive_idle,
   input  logic                 ovf_clr,
   output logic                 full,
   output logic                 empty,
   output logic                 busy,
   output logic                 ovf,
   output logic                 tx_d,
   output logic                 tx_e
);

   localparam int GW = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;
   localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);
   localparam bit HAS_GUARD = (GUARD_BITS > 0);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(MIN_DIV);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   tx_state_e            state;
   logic [1:0]           rst_sync;
   logic                 rst_i;
   logic [DIV_WIDTH-1:0] div_eff;
   logic [DIV_WIDTH-1:0] div_lat;
   logic [DIV_WIDTH-1:0] bit_cnt;
   logic [2:0]           bit_idx;
   logic [7:0]           shreg;
   logic [GW-1:0]        guard_idx;
   logic [7:0]           fifo_data;
   logic                 fifo_drop;
   logic                 bit_end;
   logic                 frame_done;
   logic                 pop;

   // Assertion passes straight through; release is retimed by two flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_sync <= 2'b11;
      end else begin
         rst_sync <= {rst_sync[0], 1'b0};
      end
   end

   assign rst_i = rst_sync[1];

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst_i),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (fifo_data),
      .full    (full),
      .empty   (empty),
      .drop    (fifo_drop)
   );

   assign div_eff = (div < DIV_MIN) ? DIV_MIN : div;
   assign bit_end = (bit_cnt == '0);
   assign busy    = (state != ST_IDLE);

   // A frame ends at the close of the last guard period, or of stop without guard.
   assign frame_done = bit_end &&
                       (((state == ST_STOP) && !HAS_GUARD) ||
                        ((state == ST_GUARD) && (guard_idx == GUARD_LAST)));

   assign pop = !empty && ((state == ST_IDLE) || frame_done);

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         tx_d      <= STOP_BIT;
         tx_e      <= 1'b0;
         ovf       <= 1'b0;
         div_lat   <= DIV_MIN;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         guard_idx <= '0;
      end else begin
         if (fifo_drop) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end

         if (pop) begin
            // New frame: divisor is captured here and held until the next pop.
            state   <= ST_START;
            tx_d    <= START_BIT;
            tx_e    <= 1'b1;
            shreg   <= fifo_data;
            div_lat <= div_eff;
            bit_cnt <= div_eff - DIV_ONE;
         end else begin
            case (state)
               ST_IDLE: begin
                  tx_d <= STOP_BIT;
                  tx_e <= drive_idle;
               end
               ST_START: begin
                  if (bit_end) begin
                     state   <= ST_DATA;
                     tx_d    <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                     bit_idx <= '0;
                     bit_cnt <= div_lat - DIV_ONE;
                  end else begin
                     bit_cnt <= bit_cnt - DIV_ONE;
                  end
               end
               ST_DATA: begin
                  if (bit_end) begin
                     bit_cnt <= div_lat - DIV_ONE;
                     if (bit_idx == LAST_BIT) begin
                        state <= ST_STOP;
                        tx_d  <= STOP_BIT;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                        tx_d    <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                     end
                  end else begin
                     bit_cnt <= bit_cnt - DIV_ONE;
                  end
               end
               ST_STOP: begin
                  if (bit_end) begin
                     if (HAS_GUARD) begin
                        state     <= ST_GUARD;
                        tx_d      <= STOP_BIT;
                        guard_idx <= '0;
                        bit_cnt   <= div_lat - DIV_ONE;
                     end else begin
                        state <= ST_IDLE;
                        tx_d  <= STOP_BIT;
                        tx_e  <= drive_idle;
                     end
                  end else begin
                     bit_cnt <= bit_cnt - DIV_ONE;
                  end
               end
               ST_GUARD: begin
                  if (bit_end) begin
                     if (guard_idx == GUARD_LAST) begin
                        state <= ST_IDLE;
                        tx_d  <= STOP_BIT;
                        tx_e  <= drive_idle;
                     end else begin
                        guard_idx <= guard_idx + GW'(1);
                        bit_cnt   <= div_lat - DIV_ONE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt - DIV_ONE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  tx_d  <= STOP_BIT;
                  tx_e  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_oe.sv
// Bench for uart_tx_oe: a line-level receiver model decodes every frame from
// tx_d/tx_e and compares against a byte queue of accepted writes.
module tb_uart_tx_oe;

   localparam int DEPTH   = 16;
   localparam int GB      = 1;
   localparam int TIMEOUT = 400;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] div = 16'd4;
   logic [7:0]  wr_data = 8'h00;
   logic        wr_en = 1'b0;
   logic        drive_idle = 1'b0;
   logic        ovf_clr = 1'b0;
   logic        full;
   logic        empty;
   logic        busy;
   logic        ovf;
   logic        tx_d;
   logic        tx_e;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   int         occ = 0;
   bit         ovf_model = 1'b0;
   logic [7:0] pat [8];

   uart_tx_oe #(
      .FIFO_DEPTH (DEPTH),
      .DIV_WIDTH  (16),
      .GUARD_BITS (GB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .div        (div),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .drive_idle (drive_idle),
      .ovf_clr    (ovf_clr),
      .full       (full),
      .empty      (empty),
      .busy       (busy),
      .ovf        (ovf),
      .tx_d       (tx_d),
      .tx_e       (tx_e)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int eff(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   // Drive one write; the model accepts it only when the FIFO has room.
   task automatic wr(input logic [7:0] b);
      wr_data = b;
      wr_en   = 1'b1;
      if (occ < DEPTH) begin
         exp_q.push_back(b);
         occ++;
      end else begin
         ovf_model = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Find a start bit, then sample every clock of start, data, stop and guard.
   task automatic rx_frame(input int d, output logic [7:0] data, output int bad,
                           output int waited, output bit found);
      int nb;
      nb     = (10 + GB) * d;
      data   = '0;
      bad    = 0;
      waited = 0;
      found  = 1'b0;
      while (!found && waited < TIMEOUT) begin
         @(negedge clk);
         if (tx_d === 1'b0) found = 1'b1;
         else waited++;
      end
      if (!found) return;
      if (occ > 0) occ--;
      for (int k = 0; k < nb; k++) begin
         int pos;
         if (k > 0) @(negedge clk);
         pos = k / d;
         if (tx_e !== 1'b1 || busy !== 1'b1) bad++;
         if (pos == 0) begin
            if (tx_d !== 1'b0) bad++;
         end else if (pos <= 8) begin
            if (k % d == 0) data[pos-1] = tx_d;
            else if (tx_d !== data[pos-1]) bad++;
         end else if (tx_d !== 1'b1) begin
            bad++;
         end
      end
   endtask

   task automatic rx_check(input int d, input bit first, output int waited);
      logic [7:0] data;
      int         bad;
      bit         found;
      rx_frame(d, data, bad, waited, found);
      check_eq("frame_found", found, 1);
      if (!found) return;
      check_eq("frame_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("frame_data", data, exp_q.pop_front());
      check_eq("frame_shape", bad, 0);
      if (!first) check_eq("b2b_gap", waited, 0);
   endtask

   task automatic check_idle_after(input int d);
      int spur;
      spur = 0;
      @(negedge clk);
      check_eq("idle_tx_d", tx_d, 1);
      check_eq("idle_tx_e", tx_e, drive_idle);
      check_eq("idle_busy", busy, 0);
      repeat ((10 + GB) * d * 2) begin
         @(negedge clk);
         if (tx_d !== 1'b1 || tx_e !== drive_idle || busy !== 1'b0) spur++;
      end
      check_eq("idle_quiet", spur, 0);
      check_eq("all_sent", exp_q.size(), 0);
      check_eq("fifo_empty", empty, 1);
   endtask

   task automatic run_case(input int dv, input int n);
      int d;
      int w;
      d   = eff(dv);
      div = 16'(dv);
      fork
         begin
            for (int i = 0; i < n; i++) wr(pat[i]);
         end
         begin
            for (int i = 0; i < n; i++) rx_check(d, i == 0, w);
         end
      join
      check_idle_after(d);
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      int w;
      int wt;
      int cnt;
      int occ_before;
      bit found;

      #1 rst = 1'b1;
      #2;
      check_eq("rst_tx_d", tx_d, 1);
      check_eq("rst_tx_e", tx_e, 0);
      check_eq("rst_full", full, 0);
      check_eq("rst_empty", empty, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ovf", ovf, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("post_rst_tx_e", tx_e, 0);

      // 0x55 at 4 clocks per bit, line released afterwards
      pat[0] = 8'h55;
      run_case(4, 1);
      // divisor below minimum
      pat[0] = 8'hA3;
      run_case(0, 1);
      // three frames back to back
      pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h03;
      run_case(3, 3);

      repeat (6) begin
         int n;
         drive_idle = 1'($urandom_range(0, 1));
         repeat (2) @(negedge clk);
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) pat[i] = 8'($urandom);
         run_case($urandom_range(0, 7), n);
      end

      // overflow while the first frame is on the line
      drive_idle = 1'b0;
      div = 16'd4;
      repeat (2) @(negedge clk);
      fork
         begin
            wr(8'hC0);
            wt = 0;
            while (busy !== 1'b1 && wt < TIMEOUT) begin
               @(negedge clk);
               wt++;
            end
            check_eq("busy_rise", busy, 1);
            repeat (2) @(negedge clk);
            for (int i = 0; i < DEPTH + 1; i++) begin
               wr(8'($urandom));
               check_eq("burst_full", full, occ == DEPTH);
               check_eq("burst_empty", empty, occ == 0);
            end
            check_eq("ovf_set", ovf, ovf_model);
            @(negedge clk);
            check_eq("ovf_sticky", ovf, ovf_model);
            occ_before = occ;
            ovf_clr = 1'b1;
            wr(8'hEE);
            ovf_clr = 1'b0;
            ovf_model = (occ_before >= DEPTH);
            check_eq("ovf_set_wins", ovf, ovf_model);
            ovf_clr = 1'b1;
            @(negedge clk);
            ovf_clr = 1'b0;
            ovf_model = 1'b0;
            check_eq("ovf_clr", ovf, ovf_model);
         end
         begin
            for (int i = 0; i < DEPTH + 1; i++) rx_check(4, i == 0, w);
         end
      join
      check_idle_after(4);

      // idle drive, then divisor change in the middle of a frame
      drive_idle = 1'b1;
      repeat (2) @(negedge clk);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_e !== 1'b1 || tx_d !== 1'b1) cnt++;
      end
      check_eq("idle_drive_hold", cnt, 0);
      div = 16'd4;
      fork
         begin
            wr(8'h3C);
            wr(8'hA5);
            wt = 0;
            while (busy !== 1'b1 && wt < TIMEOUT) begin
               @(negedge clk);
               wt++;
            end
            repeat (10) @(negedge clk);
            div = 16'd8;
         end
         begin
            rx_check(4, 1'b1, w);
            rx_check(8, 1'b0, w);
         end
      join
      check_idle_after(8);

      // reset during data bit 3 of 0x0F with five bytes queued
      drive_idle = 1'b0;
      div = 16'd4;
      repeat (2) @(negedge clk);
      wr(8'h0F);
      found = 1'b0;
      wt = 0;
      while (!found && wt < TIMEOUT) begin
         @(negedge clk);
         if (tx_d === 1'b0) found = 1'b1;
         else wt++;
      end
      check_eq("rst_frame_start", found, 1);
      for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
      repeat (12) @(negedge clk);
      check_eq("pre_rst_bit3", tx_d, 1);
      check_eq("pre_rst_busy", busy, 1);
      check_eq("pre_rst_empty", empty, 0);
      #1 rst = 1'b1;
      #1;
      check_eq("mid_rst_tx_d", tx_d, 1);
      check_eq("mid_rst_tx_e", tx_e, 0);
      check_eq("mid_rst_empty", empty, 1);
      check_eq("mid_rst_full", full, 0);
      check_eq("mid_rst_busy", busy, 0);
      exp_q.delete();
      occ = 0;
      ovf_model = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat ((10 + GB) * 4 * 3) begin
         @(negedge clk);
         if (tx_d !== 1'b1 || tx_e !== 1'b0 || busy !== 1'b0) cnt++;
      end
      check_eq("post_rst_quiet", cnt, 0);
      check_eq("post_rst_empty", empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_oe.md
UART_TX_OE -- requirements
Module: uart_tx_oe

Interface
REQ-001 The block SHALL expose parameter FIFO_DEPTH, default 16, transmit FIFO depth in bytes (power of two, 2..256).
REQ-002 The block SHALL expose parameter DIV_WIDTH, default 16, width of the baud divisor input.
REQ-003 The block SHALL expose parameter GUARD_BITS, default 1, number of bit periods tx_e stays asserted after the last stop bit.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports listed in this order:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- div  in  DIV_WIDTH  clocks per bit period; values below 2 are treated as 2.
- wr_data  in  8  byte to transmit.
- wr_en  in  1  push wr_data into the FIFO this cycle.
- drive_idle  in  1  1 = keep tx_e asserted while idle; 0 = release the line when idle.
- ovf_clr  in  1  clear the sticky overflow flag.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- busy  out  1  a frame or its guard time is in progress.
- ovf  out  1  sticky flag: write attempted while full.
- tx_d  out  1  serial data; drives the tri-state pad buffer D input.
- tx_e  out  1  pad output enable; drives the tri-state pad buffer E input.

Function
REQ-005 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-006 Each bit SHALL last exactly div_eff clocks, where div_eff = max(div,2); div SHALL be latched on leaving IDLE and held constant for the whole frame.
REQ-007 The state machine SHALL have states IDLE, START, DATA, STOP, GUARD.
REQ-008 IDLE->START SHALL occur in the cycle after empty=0 is observed; the FIFO pop and the data-shifter load SHALL happen in that same transition.
REQ-009 START->DATA, DATA->STOP (after bit 7) and STOP->GUARD SHALL each occur on the expiry of the bit counter.
REQ-010 GUARD SHALL last GUARD_BITS bit periods with tx_d=1. If GUARD_BITS=0, STOP SHALL exit directly.
REQ-011 On exit from STOP or GUARD, the FSM SHALL go to START when the FIFO is non-empty (back-to-back frames, no idle gap); otherwise it SHALL go to IDLE.
REQ-012 tx_d SHALL be registered, and SHALL be 1 in IDLE and GUARD.
REQ-013 tx_e SHALL be registered: 1 in START, DATA, STOP and GUARD; in IDLE it SHALL equal drive_idle.
REQ-014 tx_e SHALL rise no later than the cycle in which tx_d first goes to 0.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 A write SHALL be accepted when wr_en=1 and full=0.
REQ-017 A write with wr_en=1 and full=1 SHALL be dropped and SHALL set ovf. ovf SHALL clear only on ovf_clr=1 or reset; if ovf_clr and a new overflow occur in the same cycle, set wins.
REQ-018 A simultaneous write and pop on a full FIFO SHALL accept the write.
REQ-019 A simultaneous write and pop on an empty FIFO SHALL NOT pop. The byte SHALL be transmitted in the following frame slot.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH. full and empty SHALL be exact, with no off-by-one.

Reset
REQ-021 On rst=1, the block SHALL immediately and asynchronously set: FSM=IDLE, FIFO empty (full=0, empty=1), busy=0, ovf=0, tx_d=1, tx_e=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame and discard all FIFO contents.
REQ-023 Reset deassertion SHALL be synchronised to clk before it reaches the state registers.

Structure
REQ-024 Package uart_pkg SHALL hold the FSM state enumeration, the frame constants (DATA_BITS=8, START_BIT=0, STOP_BIT=1) and the minimum divisor constant (2).
REQ-025 The FIFO SHALL be a separate sub-module, uart_tx_fifo (synchronous, single clock, parameterised by depth and width). The FSM, baud counter and shifter SHALL stay in uart_tx_oe.

Verification
REQ-026 div=4, GUARD_BITS=1, drive_idle=0; write 0x55 -> after the pop, tx_d=0,1,0,1,0,1,0,1,0,1 with each bit 4 clocks long, then 4 clocks of guard with tx_e=1, then tx_e=0 and busy=0.
REQ-027 div=0 -> bit period is 2 clocks; write 0xA3 -> data bits 1,1,0,0,0,1,0,1.
REQ-028 Write 0x01,0x02,0x03 back-to-back with div=3 -> exactly 3 frames, each guard followed directly by the next start bit, tx_e continuously 1 for 3x(10+GUARD_BITS)x3 clocks.
REQ-029 Write 17 bytes with FIFO_DEPTH=16 while the transmitter is stalled (first frame in progress) -> full=1, ovf=1, exactly 16 bytes transmitted; ovf_clr pulse -> ovf=0.
REQ-030 Assert rst at data bit 3 of frame 0x0F with 5 bytes queued -> tx_d=1, tx_e=0, empty=1 asynchronously; after release, no further frames are sent.
REQ-031 drive_idle=1, no writes -> tx_e=1 and tx_d=1 steady; change div mid-frame from 4 to 8 -> the current frame keeps 4-clock bits and the next frame uses 8.
